io_port_bank: RTL

Parametrised memory-mapped I/O peripheral on the Risc16 I/O bus. It replaces the single write-only output latch and raw switch read with three things: N_OUT read-back output registers with atomic set/clear/toggle write modes, N_IN synchronised input ports, and sticky rising-edge flags with read-to-clear. It sits between the core's io_* bus and board pins (LEDs, switches, buttons).

---
 rtl/io_port_bank.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/io_port_bank.sv
// rtl/io_port_bank.sv - Risc16 I/O bus port bank: output registers, synchronised inputs, sticky edge flags
//
// Ports:
//   clk             single clock
//   rst             synchronous active-high reset
//   io_address      bus address; [15:8] selects the bank, [7:4] group, [3:0] index
//   io_write_value  write data
//   io_write_en     write strobe
//   io_read_en      read strobe
//   io_read_value   registered read data, held until the next read or reset
//   io_read_valid   one-cycle pulse per read
//   in_pins         asynchronous input ports, port j at [j*DATA_W +: DATA_W]
//   out_pins        output registers, packed the same way
module io_port_bank #(
    parameter int                DATA_W      = 16,
    parameter int                N_OUT       = 4,
    parameter int                N_IN        = 2,
    parameter logic [7:0]        BASE_HI     = 8'hFF,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] OUT_RESET   = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             io_address,
    input  logic [DATA_W-1:0]       io_write_value,
    input  logic                    io_write_en,
    input  logic                    io_read_en,
    output logic [DATA_W-1:0]       io_read_value,
    output logic                    io_read_valid,
    input  logic [N_IN*DATA_W-1:0]  in_pins,
    output logic [N_OUT*DATA_W-1:0] out_pins
);

    localparam logic [3:0] GRP_OUT  = 4'd0;
    localparam logic [3:0] GRP_SET  = 4'd1;
    localparam logic [3:0] GRP_CLR  = 4'd2;
    localparam logic [3:0] GRP_TGL  = 4'd3;
    localparam logic [3:0] GRP_IN   = 4'd4;
    localparam logic [3:0] GRP_EDGE = 4'd5;

    localparam int              CNT_W         = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] SUPPRESS_LOAD = CNT_W'(SYNC_STAGES + 1);

    logic [DATA_W-1:0] out_regs [N_OUT];
    logic [DATA_W-1:0] out_next [N_OUT];
    logic [DATA_W-1:0] sync_q   [N_IN][SYNC_STAGES];
    logic [DATA_W-1:0] prev_q   [N_IN];
    logic [DATA_W-1:0] flags    [N_IN];
    logic [DATA_W-1:0] edge_clr [N_IN];
    logic [DATA_W-1:0] rise     [N_IN];
    logic [DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]  suppress_cnt;

    logic       select;
    logic [3:0] group;
    logic [3:0] index;
    logic       wr_sel;
    logic       rd_sel;
    logic       edge_en;

    assign select  = (io_address[15:8] == BASE_HI);
    assign group   = io_address[7:4];
    assign index   = io_address[3:0];
    assign wr_sel  = io_write_en && select;
    assign rd_sel  = io_read_en && select;
    // Flags may only set once the synchroniser has flushed the zeros loaded at reset,
    // so a pin held high through reset never looks like a fresh rising edge.
    assign edge_en = (suppress_cnt == '0);

    genvar g;
    for (g = 0; g < N_OUT; g++) begin : g_out
        assign out_pins[g*DATA_W +: DATA_W] = out_regs[g];
    end

    // Next value of each output register under the four write modes.
    always_comb begin
        for (int i = 0; i < N_OUT; i++) begin
            out_next[i] = out_regs[i];
            if (wr_sel && index == 4'(i)) begin
                case (group)
                    GRP_OUT: out_next[i] = io_write_value;
                    GRP_SET: out_next[i] = out_regs[i] | io_write_value;
                    GRP_CLR: out_next[i] = out_regs[i] & ~io_write_value;
                    GRP_TGL: out_next[i] = out_regs[i] ^ io_write_value;
                    default: out_next[i] = out_regs[i];
                endcase
            end
        end
    end

    // Clear masks (read-to-clear and write-1-to-clear) and rising-edge detect per input port.
    always_comb begin
        for (int j = 0; j < N_IN; j++) begin
            edge_clr[j] = '0;
            if (group == GRP_EDGE && index == 4'(j)) begin
                if (rd_sel) begin
                    edge_clr[j] = '1;
                end
                if (wr_sel) begin
                    edge_clr[j] = edge_clr[j] | io_write_value;
                end
            end
            rise[j] = sync_q[j][SYNC_STAGES-1] & ~prev_q[j];
        end
    end

    // Read mux; unselected or unmapped addresses read as zero.
    always_comb begin
        rd_data = '0;
        if (select) begin
            case (group)
                GRP_OUT, GRP_SET, GRP_CLR, GRP_TGL: begin
                    for (int i = 0; i < N_OUT; i++) begin
                        if (index == 4'(i)) begin
                            rd_data = out_regs[i];
                        end
                    end
                end
                GRP_IN: begin
                    for (int j = 0; j < N_IN; j++) begin
                        if (index == 4'(j)) begin
                            rd_data = sync_q[j][SYNC_STAGES-1];
                        end
                    end
                end
                GRP_EDGE: begin
                    for (int j = 0; j < N_IN; j++) begin
                        if (index == 4'(j)) begin
                            rd_data = flags[j];
                        end
                    end
                end
                default: rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_OUT; i++) begin
                out_regs[i] <= OUT_RESET;
            end
            for (int j = 0; j < N_IN; j++) begin
                for (int s = 0; s < SYNC_STAGES; s++) begin
                    sync_q[j][s] <= '0;
                end
                prev_q[j] <= '0;
                flags[j]  <= '0;
            end
            suppress_cnt  <= SUPPRESS_LOAD;
            io_read_value <= '0;
            io_read_valid <= 1'b0;
        end else begin
            if (suppress_cnt != '0) begin
                suppress_cnt <= suppress_cnt - CNT_W'(1);
            end
            for (int i = 0; i < N_OUT; i++) begin
                out_regs[i] <= out_next[i];
            end
            for (int j = 0; j < N_IN; j++) begin
                sync_q[j][0] <= in_pins[j*DATA_W +: DATA_W];
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    sync_q[j][s] <= sync_q[j][s-1];
                end
                prev_q[j] <= sync_q[j][SYNC_STAGES-1];
                // A new edge outranks a clear landing on the same bit in the same cycle.
                flags[j]  <= (flags[j] & ~edge_clr[j]) | (edge_en ? rise[j] : '0);
            end
            io_read_valid <= io_read_en;
            if (io_read_en) begin
                io_read_value <= rd_data;
            end
        end
    end

endmodule
